ghostbus_arb2: RTL and testbench
================================

Name: ghostbus_arb2

Overview:
Two-requester arbiter that shares one ghostbus host port (addr/wdata/we/rstb out, rdata in) between two independent masters, e.g. a host bridge and an on-chip sequencer.
- Round-robin grant; one transaction in flight at a time.
- Per-requester req/ack handshake; registered read-data return.
- Sits at the top of the ghostbus tree, upstream of the decoded module hierarchy.

Parameters:
AW, 24, address width of requesters and ghostbus port
DW, 32, data width
RD_LAT, 1, cycles from the read-issue cycle to valid gb_din; legal range 1..15

Ports:
gb_clk  input  1  bus clock; single clock domain
gb_rst  input  1  synchronous, active-high reset
req_a  input  1  requester A request; held until ack_a
we_a  input  1  A: 1=write, 0=read; stable while req_a
addr_a  input  AW  A address; stable while req_a
wdata_a  input  DW  A write data; stable while req_a
ack_a  output  1  one-cycle completion pulse to A
rdata_a  output  DW  A read data; valid with ack_a, then held
req_b, we_b, addr_b, wdata_b, ack_b, rdata_b: same as A, for requester B
gb_addr  output  AW  ghostbus address
gb_dout  output  DW  ghostbus write data
gb_we  output  1  ghostbus write enable; one-cycle pulse
gb_rstb  output  1  ghostbus read strobe; one-cycle pulse
gb_din  input  DW  ghostbus read data
busy  output  1  high in any state other than IDLE
owner  output  1  0=A, 1=B; last granted requester

Behaviour:
- Reset values: ack_a/b=0, rdata_a/b=0, gb_addr=0, gb_dout=0, gb_we=0, gb_rstb=0, busy=0, owner=1. owner=1 means A wins the first tie.
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE, arbitration:
  - Only one req high: grant it.
  - Both high: grant the requester that is not owner.
  - On grant: capture that requester's addr/wdata/we, update owner, go to ISSUE.
- ISSUE (exactly 1 cycle):
  - gb_addr/gb_dout driven from the captured values.
  - gb_we=we, gb_rstb=~we.
  - Write: go to ACK. Read: load counter with RD_LAT-1, go to WAIT.
- WAIT:
  - gb_we=gb_rstb=0; counter decrements each cycle.
  - When counter=0, capture gb_din into rdata of the owner; go to ACK.
- ACK (1 cycle):
  - Owner's ack=1; the other requester's rdata is untouched.
  - Go to IDLE.
  - Requests are not sampled during ACK.
- gb_addr/gb_dout hold their last value outside ISSUE. gb_we and gb_rstb are never high together.
- Latency (req seen at cycle 0):
  - Write: ISSUE at cycle 1, ack at cycle 2.
  - Read: ISSUE at cycle 1, gb_din sampled at cycle 1+RD_LAT, ack at cycle 2+RD_LAT.
- Back-to-back:
  - A req still high in the cycle after ack is a new transaction.
  - Minimum spacing between transactions is 3 cycles for writes and RD_LAT+3 for reads.
  - Worst-case wait for a requester is one transaction of the other requester.
- req dropped before ack (protocol violation): the captured transaction completes and ack still pulses.
- gb_rst mid-transaction:
  - Next edge forces IDLE and clears all outputs to reset values.
  - In-flight transaction is dropped with no ack; owner returns to 1.
- Behaviour for RD_LAT outside 1..15 is undefined; add an elaboration-time check.

Decomposition:
- Package ghostbus_arb_pkg holds:
  - FSM state encoding
  - OWNER_A/OWNER_B constants
  - counter width constant RDLAT_W=4
- Sub-module ghostbus_rr2 is the combinational 2-way round-robin picker.
  - Inputs: req_a, req_b, owner. Outputs: grant_valid, grant_sel.
  - Reusable for wider arbiters later.
- Everything else (FSM, capture registers, counter) lives in ghostbus_arb2.

Test Plan:
- Write A: addr 0x000, data 0x42 -> gb_we=1 only at cycle 1 with gb_addr=0x000, gb_dout=0x42; ack_a at cycle 2; gb_rstb never high.
- Read B, RD_LAT=1: model returns 0xDEADBEEF at addr 0x40 -> gb_rstb at cycle 1; rdata_b=0xDEADBEEF with ack_b at cycle 3; rdata_a stays 0.
- Tie after reset: req_a=req_b=1 held for 10 transactions -> grants alternate A,B,A,...; 5 each; owner toggles each grant.
- Starvation: A requests continuously, B raises req once -> B granted immediately after A's current transaction; ack_b within 1 transaction + 3 cycles.
- Reset during WAIT, RD_LAT=4: gb_rst pulsed at cycle 3 of a read -> no ack_a/ack_b; busy=0 next cycle; following write completes with normal latency.
- RD_LAT=4 read: ack at cycle 6; gb_din sampled exactly at cycle 5; changing gb_din at cycles 4 and 6 does not affect rdata.

Source files
------------

// File: rtl/ghostbus_arb_pkg.sv
// ghostbus_arb_pkg: shared types and constants
// for the ghostbus host-port arbiter.
package ghostbus_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_ACK
  } arb_state_e;

  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

  localparam int RDLAT_W = 4;

endpackage

// File: rtl/ghostbus_rr2.sv
// ghostbus_rr2: combinational 2-way round-robin
// picker; on a tie the non-owner wins.
module ghostbus_rr2
  import ghostbus_arb_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic owner,
  output logic grant_valid,
  output logic grant_sel
);

  // pick a requester, rotating priority away from the last owner
  always_comb begin
    grant_valid = req_a | req_b;
    grant_sel   = OWNER_A;
    unique case (1'b1)
      (req_a & req_b):  grant_sel = ~owner;
      (req_b & ~req_a): grant_sel = OWNER_B;
      default:          grant_sel = OWNER_A;
    endcase
  end

endmodule

// File: rtl/ghostbus_arb2.sv
// ghostbus_arb2: two-requester arbiter sharing one
// ghostbus host port, one transaction in flight.
module ghostbus_arb2
  import ghostbus_arb_pkg::*;
#(
  parameter int AW     = 24,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          gb_clk,
  input  logic          gb_rst,
  input  logic          req_a,
  input  logic          we_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] wdata_a,
  output logic          ack_a,
  output logic [DW-1:0] rdata_a,
  input  logic          req_b,
  input  logic          we_b,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] wdata_b,
  output logic          ack_b,
  output logic [DW-1:0] rdata_b,
  output logic [AW-1:0] gb_addr,
  output logic [DW-1:0] gb_dout,
  output logic          gb_we,
  output logic          gb_rstb,
  input  logic [DW-1:0] gb_din,
  output logic          busy,
  output logic          owner
);

  if (RD_LAT < 1 || RD_LAT > 15) begin : g_rdlat_bad
    $error("ghostbus_arb2: RD_LAT must be 1..15");
  end

  localparam logic [RDLAT_W-1:0] RD_LAT_M1 =
    RDLAT_W'(RD_LAT - 1);

  arb_state_e           state_q, state_d;
  logic                 owner_q, owner_d;
  logic                 we_q, we_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [DW-1:0]        wdata_q, wdata_d;
  logic [RDLAT_W-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]        rdata_a_q, rdata_a_d;
  logic [DW-1:0]        rdata_b_q, rdata_b_d;
  logic                 grant_valid;
  logic                 grant_sel;

  ghostbus_rr2 u_rr (
    .req_a       (req_a),
    .req_b       (req_b),
    .owner       (owner_q),
    .grant_valid (grant_valid),
    .grant_sel   (grant_sel)
  );

  // next-state: arbitration, capture, read-latency count
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    rdata_a_d = rdata_a_q;
    rdata_b_d = rdata_b_q;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          owner_d = grant_sel;
          if (grant_sel == OWNER_B) begin
            we_d    = we_b;
            addr_d  = addr_b;
            wdata_d = wdata_b;
          end else begin
            we_d    = we_a;
            addr_d  = addr_a;
            wdata_d = wdata_a;
          end
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (we_q) begin
          state_d = ST_ACK;
        end else begin
          cnt_d   = RD_LAT_M1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          if (owner_q == OWNER_B) begin
            rdata_b_d = gb_din;
          end else begin
            rdata_a_d = gb_din;
          end
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q - RDLAT_W'(1);
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // state and capture registers
  always_ff @(posedge gb_clk) begin
    if (gb_rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWNER_B;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
    end
  end

  assign gb_addr = addr_q;
  assign gb_dout = wdata_q;
  assign gb_we   = (state_q == ST_ISSUE) & we_q;
  assign gb_rstb = (state_q == ST_ISSUE) & ~we_q;
  assign ack_a   = (state_q == ST_ACK) &
                   (owner_q == OWNER_A);
  assign ack_b   = (state_q == ST_ACK) &
                   (owner_q == OWNER_B);
  assign rdata_a = rdata_a_q;
  assign rdata_b = rdata_b_q;
  assign busy    = (state_q != ST_IDLE);
  assign owner   = owner_q;

endmodule

// File: tb/tb_ghostbus_arb2.sv
// tb_ghostbus_arb2: two arbiters (RD_LAT 1 and 4)
// checked cycle by cycle against a timeline model.
module tb_ghostbus_arb2;

  localparam int AW = 24;
  localparam int DW = 32;

  typedef struct packed {
    logic          who;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst     [2];
  logic          req_a   [2];
  logic          we_a    [2];
  logic [AW-1:0] addr_a  [2];
  logic [DW-1:0] wdata_a [2];
  logic          ack_a   [2];
  logic [DW-1:0] rdata_a [2];
  logic          req_b   [2];
  logic          we_b    [2];
  logic [AW-1:0] addr_b  [2];
  logic [DW-1:0] wdata_b [2];
  logic          ack_b   [2];
  logic [DW-1:0] rdata_b [2];
  logic [AW-1:0] gb_addr [2];
  logic [DW-1:0] gb_dout [2];
  logic          gb_we   [2];
  logic          gb_rstb [2];
  logic [DW-1:0] gb_din  [2];
  logic          busy    [2];
  logic          owner   [2];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  logic          om  [2];
  logic [AW-1:0] la  [2];
  logic [DW-1:0] ld  [2];
  logic [DW-1:0] erd [2][2];
  logic [DW-1:0] mm  [2][256];

  ghostbus_arb2 #(.AW(AW), .DW(DW), .RD_LAT(1)) u_d0 (
    .gb_clk(clk), .gb_rst(rst[0]),
    .req_a(req_a[0]), .we_a(we_a[0]),
    .addr_a(addr_a[0]), .wdata_a(wdata_a[0]),
    .ack_a(ack_a[0]), .rdata_a(rdata_a[0]),
    .req_b(req_b[0]), .we_b(we_b[0]),
    .addr_b(addr_b[0]), .wdata_b(wdata_b[0]),
    .ack_b(ack_b[0]), .rdata_b(rdata_b[0]),
    .gb_addr(gb_addr[0]), .gb_dout(gb_dout[0]),
    .gb_we(gb_we[0]), .gb_rstb(gb_rstb[0]),
    .gb_din(gb_din[0]),
    .busy(busy[0]), .owner(owner[0])
  );

  ghostbus_arb2 #(.AW(AW), .DW(DW), .RD_LAT(4)) u_d1 (
    .gb_clk(clk), .gb_rst(rst[1]),
    .req_a(req_a[1]), .we_a(we_a[1]),
    .addr_a(addr_a[1]), .wdata_a(wdata_a[1]),
    .ack_a(ack_a[1]), .rdata_a(rdata_a[1]),
    .req_b(req_b[1]), .we_b(we_b[1]),
    .addr_b(addr_b[1]), .wdata_b(wdata_b[1]),
    .ack_b(ack_b[1]), .rdata_b(rdata_b[1]),
    .gb_addr(gb_addr[1]), .gb_dout(gb_dout[1]),
    .gb_we(gb_we[1]), .gb_rstb(gb_rstb[1]),
    .gb_din(gb_din[1]),
    .busy(busy[1]), .owner(owner[1])
  );

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic logic [DW-1:0] init_val(input int i);
    if (i == 'h40) return 32'hDEADBEEF;
    return 32'h5A5A_0000 + DW'(i);
  endfunction

  function automatic txn_t mk(input logic we,
                              input logic [AW-1:0] a,
                              input logic [DW-1:0] w);
    txn_t t;
    t.who = 1'b0;
    t.we = we;
    t.addr = a;
    t.wdata = w;
    return t;
  endfunction

  function automatic txn_t rnd_txn();
    logic [AW-1:0] a;
    logic we;
    a = AW'($urandom);
    a[7:0] = 8'($urandom_range(0, 7));
    we = 1'($urandom_range(0, 1));
    return mk(we, a, $urandom);
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // bus slave: memory with exact RD_LAT return,
  // random junk on gb_din in every other cycle
  logic [DW-1:0] smem [2][256];
  int            due  [2];
  logic [DW-1:0] dval [2];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("d%0d we_rstb_excl", g),
          64'(gb_we[g] & gb_rstb[g]), 64'd0);
      if (gb_we[g] === 1'b1)
        smem[g][gb_addr[g][7:0]] = gb_dout[g];
      if (gb_rstb[g] === 1'b1) begin
        due[g] = cyc + lat(g);
        dval[g] = smem[g][gb_addr[g][7:0]];
      end
      gb_din[g] = (cyc == due[g]) ? dval[g] : $urandom;
    end
  end

  task automatic cyc_chk(input int d, input string tg,
                         input logic [1:0] eack,
                         input logic ewe,
                         input logic erstb,
                         input logic ebusy,
                         input logic eown);
    string p;
    p = $sformatf("d%0d %s", d, tg);
    chk({p, " ack_a"}, 64'(ack_a[d]), 64'(eack[0]));
    chk({p, " ack_b"}, 64'(ack_b[d]), 64'(eack[1]));
    chk({p, " gb_we"}, 64'(gb_we[d]), 64'(ewe));
    chk({p, " gb_rstb"}, 64'(gb_rstb[d]), 64'(erstb));
    chk({p, " busy"}, 64'(busy[d]), 64'(ebusy));
    chk({p, " owner"}, 64'(owner[d]), 64'(eown));
    chk({p, " gb_addr"}, 64'(gb_addr[d]), 64'(la[d]));
    chk({p, " gb_dout"}, 64'(gb_dout[d]), 64'(ld[d]));
    chk({p, " rdata_a"}, 64'(rdata_a[d]),
        64'(erd[d][0]));
    chk({p, " rdata_b"}, 64'(rdata_b[d]),
        64'(erd[d][1]));
  endtask

  // one or two transactions starting from IDLE; B may
  // raise its request dly_b cycles after the start
  task automatic run2(input int d,
                      input bit en_a, input bit en_b,
                      input int dly_b,
                      input txn_t ta, input txn_t tx);
    txn_t t [2];
    int st [2];
    int ak [2];
    logic [DW-1:0] rv [2];
    int n, last;
    bit first;
    logic ewe, erstb, ebusy, eown;
    logic [1:0] eack;
    ta.who = 1'b0;
    tx.who = 1'b1;
    if (en_a && en_b)
      first = (dly_b == 0) ? ~om[d] : 1'b0;
    else
      first = en_b;
    n = (en_a && en_b) ? 2 : 1;
    t[0] = first ? tx : ta;
    t[1] = first ? ta : tx;
    st[0] = 0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) st[i] = ak[i-1] + 1;
      ak[i] = st[i] + (t[i].we ? 2 : 2 + lat(d));
      rv[i] = mm[d][t[i].addr[7:0]];
      if (t[i].we) mm[d][t[i].addr[7:0]] = t[i].wdata;
    end
    last = ak[n-1];
    req_a[d] = en_a;
    we_a[d] = ta.we;
    addr_a[d] = ta.addr;
    wdata_a[d] = ta.wdata;
    req_b[d] = en_b && (dly_b == 0);
    we_b[d] = tx.we;
    addr_b[d] = tx.addr;
    wdata_b[d] = tx.wdata;
    eown = om[d];
    @(posedge clk);
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      ewe = 1'b0;
      erstb = 1'b0;
      ebusy = 1'b0;
      eack = 2'b00;
      for (int i = 0; i < n; i++) begin
        if (k == st[i] + 1) begin
          ewe = t[i].we;
          erstb = ~t[i].we;
          la[d] = t[i].addr;
          ld[d] = t[i].wdata;
          eown = t[i].who;
        end
        if (k > st[i] && k <= ak[i]) ebusy = 1'b1;
        if (k == ak[i]) begin
          eack[t[i].who] = 1'b1;
          if (!t[i].we) erd[d][t[i].who] = rv[i];
        end
      end
      cyc_chk(d, $sformatf("c%0d", k), eack,
              ewe, erstb, ebusy, eown);
      if (eack[0]) req_a[d] = 1'b0;
      if (eack[1]) req_b[d] = 1'b0;
      if (en_b && dly_b == k) req_b[d] = 1'b1;
    end
    om[d] = t[n-1].who;
    @(posedge clk);
    @(negedge clk);
    cyc_chk(d, "idle", 2'b00, 1'b0, 1'b0, 1'b0, om[d]);
  endtask

  task automatic model_reset(input int d);
    om[d] = 1'b1;
    la[d] = '0;
    ld[d] = '0;
    erd[d][0] = '0;
    erd[d][1] = '0;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1;
      req_a[d] = 1'b0;
      we_a[d] = 1'b0;
      addr_a[d] = '0;
      wdata_a[d] = '0;
      req_b[d] = 1'b0;
      we_b[d] = 1'b0;
      addr_b[d] = '0;
      wdata_b[d] = '0;
      due[d] = -1;
      dval[d] = '0;
      model_reset(d);
      for (int i = 0; i < 256; i++) begin
        mm[d][i] = init_val(i);
        smem[d][i] = init_val(i);
      end
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++)
      cyc_chk(d, "reset", 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // RD_LAT=1: write A, read B, late-arriving B
    run2(0, 1, 0, 0, mk(1'b1, 24'h000000, 32'h42),
         mk(1'b0, '0, '0));
    run2(0, 0, 1, 0, mk(1'b0, '0, '0),
         mk(1'b0, 24'h000040, '0));
    run2(0, 1, 1, 1, mk(1'b0, 24'h000003, '0),
         mk(1'b1, 24'h000005, 32'h1234_5678));

    // RD_LAT=4: ties from reset alternate A,B
    for (int i = 0; i < 5; i++)
      run2(1, 1, 1, 0, rnd_txn(), rnd_txn());
    run2(1, 1, 0, 0, mk(1'b0, 24'h000040, '0),
         mk(1'b0, '0, '0));

    // reset in the middle of a RD_LAT=4 read
    req_a[1] = 1'b1;
    we_a[1] = 1'b0;
    addr_a[1] = 24'h000010;
    @(posedge clk);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("d1 rstw c%0d ack_a", k),
          64'(ack_a[1]), 64'd0);
      chk($sformatf("d1 rstw c%0d ack_b", k),
          64'(ack_b[1]), 64'd0);
      if (k == 3) rst[1] = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    rst[1] = 1'b0;
    req_a[1] = 1'b0;
    model_reset(1);
    cyc_chk(1, "after_rst", 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      cyc_chk(1, "post_rst", 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    run2(1, 1, 0, 0, mk(1'b1, 24'h000006, 32'hCAFE_F00D),
         mk(1'b0, '0, '0));

    // randomized mix on both latencies
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 12; i++) begin
        int m;
        int dl;
        m = $urandom_range(0, 2);
        dl = (m == 2) ? $urandom_range(0, 1) : 0;
        run2(d, m != 1, m != 0, dl, rnd_txn(), rnd_txn());
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
